// File: rtl/benzaiten_mem_pkg.sv
// Shared memory-path types for the internal RAM responder.
// Holds access-length encoding, responder state encoding and byte-count helper.
package benzaiten_mem_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    LEN_B = 2'd0,
    LEN_H = 2'd1,
    LEN_T = 2'd2,
    LEN_W = 2'd3
  } oplen_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACC_A = 3'd1,
    ACC_B = 3'd2,
    RESP  = 3'd3,
    HOLD  = 3'd4
  } iram_state_t;

  // Number of bytes moved by an access of the given length code (1..4).
  function automatic logic [2:0] nbytes(oplen_t len);
    return {1'b0, len} + 3'd1;
  endfunction

endpackage

// File: rtl/iram_byte_bank.sv
// Four byte-wide single-port block RAMs sharing one word index.
// Per-lane write enable, registered read data (1-cycle latency, held when idle).
module iram_byte_bank #(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] idx_i,
  input  logic          re_i,
  input  logic [3:0]    we_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  for (genvar lane = 0; lane < 4; lane++) begin : g_lane
    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_q;

    // Byte-lane RAM port: optional write, optional registered read.
    always_ff @(posedge clk) begin
      if (we_i[lane]) begin
        mem_q[idx_i] <= wdata_i[lane*8 +: 8];
      end
      if (re_i) begin
        rd_q <= mem_q[idx_i];
      end
    end

    assign rdata_o[lane*8 +: 8] = rd_q;
  end

endmodule

// File: rtl/iram_responder.sv
// Internal RAM responder on the enable/valid memory handshake.
// Serves 1-4 byte reads/writes at any byte alignment, splitting accesses that
// straddle a word boundary into two RAM cycles.
// Optional build macro IRAM_BOUNDS_EN: adds the err port and faults accesses
// beyond DEPTH words instead of wrapping.
module iram_responder
  import benzaiten_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        valid,
  input  logic [24:0] addr,
  input  logic [1:0]  oplen,
  input  logic [1:0]  writeEnable,
  input  logic [31:0] data,
  output logic [31:0] result
`ifdef IRAM_BOUNDS_EN
  ,
  output logic        err
`endif
);

  iram_state_t   state_q, state_d;
  logic [AW-1:0] idx_q;
  logic [1:0]    off_q;
  oplen_t        len_q;
  logic          wr_q;
  logic [31:0]   data_q;
  logic          span_q;
  logic [31:0]   worda_q;
  logic [31:0]   result_q, result_d;
  logic          valid_q;

  logic          accept;
  logic [2:0]    nb_in;
  logic          span_in;
  logic          fault_in;

  logic [2:0]    nb_q;
  logic [3:0]    len_mask;
  logic [7:0]    lane_mask;
  logic [63:0]   wide_data;
  logic [31:0]   rd_lo;
  logic [31:0]   rd_shift;
  logic [31:0]   byte_mask;
  logic [31:0]   rd_result;

  logic [AW-1:0] bank_idx;
  logic          bank_re;
  logic [3:0]    bank_we;
  logic [31:0]   bank_wdata;
  logic [31:0]   rdata;

  logic          unused_bits;

`ifdef IRAM_BOUNDS_EN
  logic          fault_q;
  logic          err_q, err_d;
  logic [31:0]   widx_full;
`endif

  assign unused_bits = ^{addr[24:AW+2], writeEnable[1]};

  assign accept  = (state_q == IDLE) && enable;
  assign nb_in   = nbytes(oplen_t'(oplen));
  assign span_in = ({1'b0, addr[1:0]} + nb_in) > 3'(WORD_BYTES);

`ifdef IRAM_BOUNDS_EN
  assign widx_full = {9'b0, addr[24:2]};
  assign fault_in  = (widx_full >= DEPTH) || (span_in && ((widx_full + 32'd1) >= DEPTH));
`else
  assign fault_in  = 1'b0;
`endif

  // Byte lanes touched in word A are mask[3:0], lanes spilling into word B are
  // mask[7:4]; write data is shifted the same way across the 64-bit pair.
  assign nb_q      = nbytes(len_q);
  assign len_mask  = 4'b1111 >> (3'd4 - nb_q);
  assign lane_mask = {4'b0, len_mask} << off_q;
  assign wide_data = {32'b0, data_q} << {off_q, 3'b000};

  // Word A comes straight from the RAM when not spanning, otherwise from the
  // copy taken while word B was being read.
  assign rd_lo     = span_q ? worda_q : rdata;
  assign rd_shift  = 32'({rdata, rd_lo} >> {off_q, 3'b000});
  assign byte_mask = 32'hFFFF_FFFF >> {(3'd4 - nb_q), 3'b000};
  assign rd_result = rd_shift & byte_mask;

  // Next-state logic for the request sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = fault_in ? RESP : ACC_A;
      ACC_A:   state_d = span_q ? ACC_B : RESP;
      ACC_B:   state_d = RESP;
      RESP:    state_d = HOLD;
      HOLD:    if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM port drive; writes are suppressed while reset is asserted so an
  // aborted spanning write never reaches word B.
  always_comb begin
    bank_idx   = idx_q;
    bank_re    = 1'b0;
    bank_we    = '0;
    bank_wdata = wide_data[31:0];
    if (state_q == ACC_B) begin
      bank_idx   = idx_q + AW'(1);
      bank_wdata = wide_data[63:32];
    end
    if (state_q == ACC_A || state_q == ACC_B) begin
      bank_re = !wr_q;
      if (wr_q && rst_n) begin
        bank_we = (state_q == ACC_A) ? lane_mask[3:0] : lane_mask[7:4];
      end
    end
  end

  // Response register updates: read data lands in RESP, writes leave it alone.
  always_comb begin
    result_d = result_q;
    if (state_q == RESP && !wr_q) begin
      result_d = rd_result;
    end
`ifdef IRAM_BOUNDS_EN
    err_d = err_q;
    if (accept) begin
      err_d = 1'b0;
    end
    if (state_q == RESP && fault_q) begin
      result_d = '0;
      err_d    = 1'b1;
    end
`endif
  end

  // State, request latch and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      result_q <= '0;
      idx_q    <= '0;
      off_q    <= '0;
      len_q    <= LEN_B;
      wr_q     <= 1'b0;
      data_q   <= '0;
      span_q   <= 1'b0;
      worda_q  <= '0;
`ifdef IRAM_BOUNDS_EN
      fault_q  <= 1'b0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      valid_q  <= (state_q == RESP);
      result_q <= result_d;
      if (accept) begin
        idx_q  <= addr[AW+1:2];
        off_q  <= addr[1:0];
        len_q  <= oplen_t'(oplen);
        wr_q   <= writeEnable[0];
        data_q <= data;
        span_q <= span_in;
`ifdef IRAM_BOUNDS_EN
        fault_q <= fault_in;
`endif
      end
      if (state_q == ACC_B) begin
        worda_q <= rdata;
      end
`ifdef IRAM_BOUNDS_EN
      err_q <= err_d;
`endif
    end
  end

  iram_byte_bank #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_bank (
    .clk     (clk),
    .idx_i   (bank_idx),
    .re_i    (bank_re),
    .we_i    (bank_we),
    .wdata_i (bank_wdata),
    .rdata_o (rdata)
  );

  assign valid  = valid_q;
  assign result = result_q;
`ifdef IRAM_BOUNDS_EN
  assign err    = err_q;
`endif

endmodule

// File: doc/iram_responder.md
Name: iram_responder

Overview:
Responder end of the memory enable/valid request handshake. It serves byte-addressed read and write requests from the memory-controller arbiter out of on-chip block RAM. Supports 1–4 byte accesses at any byte alignment, including accesses that straddle two 32-bit words. Sits beside the SDRAM path as the low-latency internal RAM target.

Parameters:
DEPTH, 4096, number of 32-bit words (power of two)
AW, $clog2(DEPTH), word-index width

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
enable  in  1  request strobe; held high by requester until it sees valid, dropped within 1 cycle after
valid  out  1  one-cycle completion pulse
addr  in  25  byte address; word index = addr[AW+1:2], offset = addr[1:0]
oplen  in  2  access length minus one (0=1B, 1=2B, 2=3B, 3=4B)
writeEnable  in  2  bit0: 1=write, 0=read; bit1 reserved, ignored
data  in  32  write data, right-aligned, little-endian
result  out  32  read data, right-aligned, zero-extended (requester sign-extends)
err  out  1  only with IRAM_BOUNDS_EN: access faulted

Behaviour:
- Reset: state IDLE, valid=0, result=0, err=0. RAM contents are not cleared. Reset mid-transaction aborts immediately; a pending second-word write is not performed.
- States: IDLE, ACC_A, ACC_B, RESP, HOLD.
- IDLE: on enable=1, latch addr/oplen/writeEnable/data. Compute nbytes=oplen+1 and span=(offset+nbytes>4). Go to ACC_A. Input changes after latch are ignored.
- ACC_A: operate on word A=index. Read: issue sync read. Write: per-lane byte enables for lanes offset..min(3,offset+nbytes-1); data shifted left by 8*offset. Next state ACC_B if span, else RESP.
- ACC_B: word B=(index+1) mod DEPTH; lanes 0..(offset+nbytes-5); data bytes from (4-offset) upward. Next state RESP.
- RESP: valid=1 for exactly this cycle. For reads, result = ({B,A} >> 8*offset) masked to nbytes. Result is held stable until the next RESP. Next state HOLD.
- HOLD: wait for enable=0, then go to IDLE. An enable still high in the cycle after valid is never treated as a new request.
- Latency, from the edge that samples enable in IDLE to valid high: 2 cycles non-spanning, 3 cycles spanning, for both reads and writes.
- Reads never modify RAM. Writes leave result unchanged.
- If the requester drops enable during ACC_A/ACC_B, the transaction still completes and valid still pulses.
- Without the macro, word indices wrap modulo DEPTH; a span at word DEPTH-1 continues at word 0.

Optional Feature:
IRAM_BOUNDS_EN
- Defined: err port exists. In IDLE, if addr[24:2] >= DEPTH, or span is set and addr[24:2]+1 >= DEPTH, skip ACC_A/ACC_B and go directly to RESP one cycle later. RESP then has valid=1, err=1, result=0, and no RAM write. err clears when the next transaction is accepted.
- Undefined: no err port; wrap-around behaviour as above.

Decomposition:
- Package benzaiten_mem_pkg: oplen_t enum (LEN_B, LEN_H, LEN_T, LEN_W), iram_state_t enum, function nbytes(oplen_t), constant WORD_BYTES=4.
- Sub-module iram_byte_bank: four byte-wide single-port sync-read RAMs with per-lane write enable, 1-cycle read latency, shared word index. It is the only storage.

Test Plan:
- Write 0xDEADBEEF at 0x10, oplen 3 -> valid 2 cycles later; read 0x10, oplen 3 -> result 0xDEADBEEF, valid 2 cycles after enable.
- Read 0x13, oplen 0 -> 0x000000DE; read 0x12, oplen 1 -> 0x0000DEAD.
- Spanning write 0xA55A at 0x17, oplen 1 -> valid after 3 cycles; read 0x14 word -> byte3=0x5A; read 0x18 -> byte0=0xA5; read 0x17, oplen 1 -> 0x0000A55A with 3-cycle latency.
- Enable held high 1 cycle past valid, then low 1 cycle, then high -> exactly two valid pulses; no spurious third.
- rst_n low during ACC_B of a spanning write at 0x1E -> word 0x1C updated, word 0x20 unchanged, valid never pulses, IDLE after reset.
- IRAM_BOUNDS_EN, DEPTH=4096: write at 0x3FFE, oplen 3 -> valid after 1 cycle, err=1, words 0xFFF and 0x000 unchanged. Without the macro, the same write wraps: word 0x000 bytes 0–1 are written.
